// File: rtl/mmio_periph_pkg.sv
// Shared types and register map for the memory-mapped peripheral unit.
// Offsets are relative to the unit's base address.
package mmio_periph_pkg;

    typedef enum logic [1:0] {
        MEM_MSG_READ  = 2'd0,
        MEM_MSG_WRITE = 2'd1
    } t_op;

    localparam logic [31:0] OFF_CYCLE_LO  = 32'h00;
    localparam logic [31:0] OFF_CYCLE_HI  = 32'h04;
    localparam logic [31:0] OFF_TIMER_CMP = 32'h08;
    localparam logic [31:0] OFF_CTRL      = 32'h0C;
    localparam logic [31:0] OFF_SCRATCH0  = 32'h10;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FIRED_BIT = 1;

    // Opaque tag is prepended by the top, where its width is known.
    typedef struct packed {
        t_op         op;
        logic [1:0]  origin;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } t_resp_base;

    function automatic logic [31:0] merge_strb(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_resp_fifo.sv
// Depth-parameterised val/rdy FIFO; pointers wrap explicitly so any
// depth >= 1 works, not just powers of two.
module mmio_resp_fifo #(
    parameter int p_width = 8,
    parameter int p_depth = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_val,
    output logic               enq_rdy,
    input  logic [p_width-1:0] enq_data,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic [p_width-1:0] deq_data
);

    localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam int c_cnt_w = $clog2(p_depth + 1);
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(p_depth - 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(p_depth);

    logic [p_width-1:0] mem_q [p_depth];
    logic [p_width-1:0] mem_d [p_depth];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               enq;
    logic               deq;

    assign enq_rdy  = (cnt_q != c_full);
    assign deq_val  = (cnt_q != '0);
    assign deq_data = mem_q[rd_ptr_q];
    assign enq      = enq_val & enq_rdy;
    assign deq      = deq_val & deq_rdy;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            mem_d[wr_ptr_q] = enq_data;
            wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + 1'b1;
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({enq, deq})
            2'b10:   cnt_d = cnt_q + c_cnt_w'(1);
            2'b01:   cnt_d = cnt_q - c_cnt_w'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mmio_periph_unit.sv
// Memory-mapped peripheral: 64-bit cycle counter, compare timer with irq,
// and byte-writable scratch registers behind a buffered response path.
module mmio_periph_unit
    import mmio_periph_pkg::*;
#(
    parameter int          p_opaq_bits   = 8,
    parameter logic [31:0] p_base_addr   = 32'hFFFFFF00,
    parameter int          p_num_scratch = 4,
    parameter int          p_resp_depth  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  t_op                    req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [1:0]             req_origin,
    input  logic [31:0]            req_addr,
    input  logic [3:0]             req_strb,
    input  logic [31:0]            req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output t_op                    resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [1:0]             resp_origin,
    output logic [31:0]            resp_addr,
    output logic [3:0]             resp_strb,
    output logic [31:0]            resp_data,
    output logic                   irq
);

    localparam int c_sidx_w = (p_num_scratch > 1) ? $clog2(p_num_scratch) : 1;

    typedef struct packed {
        logic [p_opaq_bits-1:0] opaque;
        t_resp_base             base;
    } t_resp_entry;

    localparam int c_entry_w = $bits(t_resp_entry);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] hi_snap_q, hi_snap_d;
    logic [31:0] cmp_q, cmp_d;
    logic        timer_en_q, timer_en_d;
    logic        fired_q, fired_d;
    logic [31:0] scratch_q [p_num_scratch];
    logic [31:0] scratch_d [p_num_scratch];

    logic                fire;
    logic                is_rd;
    logic                is_wr;
    logic [31:0]         off_w;
    logic [31:0]         scr_word;
    logic                scr_hit;
    logic [c_sidx_w-1:0] scr_idx;
    logic [31:0]         rd_data;
    t_resp_entry         enq_entry;
    t_resp_entry         deq_entry;

    // Byte lanes within a word do not affect decode.
    assign off_w    = (req_addr - p_base_addr) & 32'hFFFF_FFFC;
    assign scr_word = (off_w - OFF_SCRATCH0) >> 2;
    assign scr_hit  = (off_w >= OFF_SCRATCH0) &&
                      (scr_word < 32'(p_num_scratch));
    assign scr_idx  = scr_word[c_sidx_w-1:0];

    assign fire  = req_val & req_rdy;
    assign is_rd = (req_op == MEM_MSG_READ);
    assign is_wr = (req_op == MEM_MSG_WRITE);
    assign irq   = fired_q & timer_en_q;

    always_comb begin
        rd_data = '0;
        case (off_w)
            OFF_CYCLE_LO:  rd_data = cnt_q[31:0];
            OFF_CYCLE_HI:  rd_data = hi_snap_q;
            OFF_TIMER_CMP: rd_data = cmp_q;
            OFF_CTRL: begin
                rd_data[CTRL_EN_BIT]    = timer_en_q;
                rd_data[CTRL_FIRED_BIT] = fired_q;
            end
            default: begin
                if (scr_hit) rd_data = scratch_q[scr_idx];
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q + 64'd1;
        hi_snap_d  = hi_snap_q;
        cmp_d      = cmp_q;
        timer_en_d = timer_en_q;
        fired_d    = fired_q;
        scratch_d  = scratch_q;
        if (fire && is_rd && (off_w == OFF_CYCLE_LO)) begin
            hi_snap_d = cnt_q[63:32];
        end
        if (fire && is_wr) begin
            case (off_w)
                OFF_TIMER_CMP: cmp_d = merge_strb(cmp_q, req_data, req_strb);
                OFF_CTRL: begin
                    if (req_strb[0]) begin
                        timer_en_d = req_data[CTRL_EN_BIT];
                        if (req_data[CTRL_FIRED_BIT]) fired_d = 1'b0;
                    end
                end
                default: begin
                    if (scr_hit) begin
                        scratch_d[scr_idx] =
                            merge_strb(scratch_q[scr_idx], req_data, req_strb);
                    end
                end
            endcase
        end
        // A match outranks a same-cycle write-1-to-clear.
        if (timer_en_q && (cnt_q[31:0] == cmp_q)) fired_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            hi_snap_q  <= '0;
            cmp_q      <= 32'hFFFF_FFFF;
            timer_en_q <= 1'b0;
            fired_q    <= 1'b0;
            scratch_q  <= '{default: '0};
        end else begin
            cnt_q      <= cnt_d;
            hi_snap_q  <= hi_snap_d;
            cmp_q      <= cmp_d;
            timer_en_q <= timer_en_d;
            fired_q    <= fired_d;
            scratch_q  <= scratch_d;
        end
    end

    always_comb begin
        enq_entry             = '0;
        enq_entry.opaque      = req_opaque;
        enq_entry.base.op     = req_op;
        enq_entry.base.origin = req_origin;
        enq_entry.base.addr   = req_addr;
        enq_entry.base.strb   = req_strb;
        enq_entry.base.data   = is_rd ? rd_data : 32'd0;
    end

    mmio_resp_fifo #(
        .p_width (c_entry_w),
        .p_depth (p_resp_depth)
    ) u_resp_fifo (
        .clk      (clk),
        .rst      (rst),
        .enq_val  (fire),
        .enq_rdy  (req_rdy),
        .enq_data (enq_entry),
        .deq_val  (resp_val),
        .deq_rdy  (resp_rdy),
        .deq_data (deq_entry)
    );

    assign resp_op     = deq_entry.base.op;
    assign resp_opaque = deq_entry.opaque;
    assign resp_origin = deq_entry.base.origin;
    assign resp_addr   = deq_entry.base.addr;
    assign resp_strb   = deq_entry.base.strb;
    assign resp_data   = deq_entry.base.data;

endmodule

// File: tb/tb_mmio_periph_unit.sv
// Scoreboard bench for mmio_periph_unit: directed requests push expected
// responses; a monitor pops and compares each delivered response.
module tb_mmio_periph_unit;
    import mmio_periph_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFFFF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    t_op         req_op;
    logic [7:0]  req_opaque;
    logic [1:0]  req_origin;
    logic [31:0] req_addr;
    logic [3:0]  req_strb;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    t_op         resp_op;
    logic [7:0]  resp_opaque;
    logic [1:0]  resp_origin;
    logic [31:0] resp_addr;
    logic [3:0]  resp_strb;
    logic [31:0] resp_data;
    logic        irq;

    always #5 clk = ~clk;

    mmio_periph_unit #(
        .p_opaq_bits   (8),
        .p_base_addr   (BASE),
        .p_num_scratch (4),
        .p_resp_depth  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_opaque  (req_opaque),
        .req_origin  (req_origin),
        .req_addr    (req_addr),
        .req_strb    (req_strb),
        .req_data    (req_data),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_opaque (resp_opaque),
        .resp_origin (resp_origin),
        .resp_addr   (resp_addr),
        .resp_strb   (resp_strb),
        .resp_data   (resp_data),
        .irq         (irq)
    );

    typedef struct {
        t_op         op;
        logic [7:0]  opq;
        logic [1:0]  org;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [63:0] cyc = '0;
    logic [63:0] bias = '0;
    logic [31:0] snap_m = '0;

    // Reference cycle count: cycles elapsed since reset release.
    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 64'd1;
    end

    always @(negedge clk) begin
        if (!rst && resp_val && resp_rdy) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL resp_unexpected: got opq=%0h data=%0h want none",
                         resp_opaque, resp_data);
            end else begin
                mon_e = sb.pop_front();
                if ({resp_op, resp_opaque, resp_origin, resp_addr, resp_strb, resp_data} !==
                    {mon_e.op, mon_e.opq, mon_e.org, mon_e.addr, mon_e.strb, mon_e.data}) begin
                    bad++;
                    $display("FAIL resp_%0h: got op=%0d org=%0d addr=%0h strb=%0h data=%0h want op=%0d org=%0d addr=%0h strb=%0h data=%0h (opq got %0h)",
                             mon_e.opq, resp_op, resp_origin, resp_addr, resp_strb, resp_data,
                             mon_e.op, mon_e.org, mon_e.addr, mon_e.strb, mon_e.data, resp_opaque);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // kind 0: expect xd; 1: expect model CYCLE_LO (and snapshot hi); 2: expect snapshot
    task automatic send(input t_op op, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [7:0] opq,
                        input logic [1:0] org, input int kind, input logic [31:0] xd);
        exp_t        e;
        int          n;
        logic [63:0] c;
        req_val    = 1'b1;
        req_op     = op;
        req_addr   = addr;
        req_strb   = strb;
        req_data   = data;
        req_opaque = opq;
        req_origin = org;
        n = 0;
        @(negedge clk);
        while (!req_rdy) begin
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL req_timeout_%0h: got req_rdy=0 want 1 within 60 cycles", opq);
                req_val = 1'b0;
                return;
            end
            @(negedge clk);
        end
        e.op   = op;
        e.opq  = opq;
        e.org  = org;
        e.addr = addr;
        e.strb = strb;
        e.data = xd;
        if (kind == 1) begin
            c = cyc + bias;
            e.data = c[31:0];
            snap_m = c[63:32];
        end else if (kind == 2) begin
            e.data = snap_m;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    task automatic wait_cnt(input logic [63:0] v);
        int n;
        n = 0;
        while (cyc + bias != v) begin
            n++;
            if (n > 300) begin
                total++;
                bad++;
                $display("FAIL wait_cnt: got %0h want %0h", cyc + bias, v);
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending responses want 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_val    = 1'b0;
        req_op     = MEM_MSG_READ;
        req_opaque = '0;
        req_origin = '0;
        req_addr   = '0;
        req_strb   = '0;
        req_data   = '0;
        resp_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_req_rdy", 64'(req_rdy), 64'd1);
        chk("reset_resp_val", 64'(resp_val), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        @(posedge clk);
        #1;

        // Counter read at cycle 10, then snapshot of the high word.
        wait_cnt(64'd10);
        send(MEM_MSG_READ, BASE + 32'h00, 4'hF, 32'h0, 8'h11, 2'd1, 0, 32'd10);
        send(MEM_MSG_READ, BASE + 32'h04, 4'hF, 32'h0, 8'h12, 2'd2, 0, 32'd0);

        // Timer fires the cycle after the counter reaches 20.
        send(MEM_MSG_WRITE, BASE + 32'h08, 4'hF, 32'd20, 8'h13, 2'd3, 0, 32'd0);
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'hF, 32'd1, 8'h14, 2'd0, 0, 32'd0);
        wait_cnt(64'd20);
        @(negedge clk);
        chk("irq_before_match", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("irq_after_match", 64'(irq), 64'd1);
        @(posedge clk);
        #1;
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'hF, 32'h2, 8'h15, 2'd0, 0, 32'd0);
        @(negedge clk);
        chk("irq_after_w1c", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        send(MEM_MSG_READ, BASE + 32'h0C, 4'hF, 32'h0, 8'h16, 2'd0, 0, 32'd0);

        // W1C in the exact match cycle: the set wins.
        send(MEM_MSG_WRITE, BASE + 32'h08, 4'hF, 32'd60, 8'h17, 2'd1, 0, 32'd0);
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'hF, 32'd1, 8'h18, 2'd1, 0, 32'd0);
        wait_cnt(64'd60);
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'hF, 32'h3, 8'h19, 2'd1, 0, 32'd0);
        @(negedge clk);
        chk("irq_set_wins", 64'(irq), 64'd1);
        @(posedge clk);
        #1;
        send(MEM_MSG_READ, BASE + 32'h0C, 4'hF, 32'h0, 8'h1A, 2'd2, 0, 32'h3);
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'h1, 32'h0, 8'h1B, 2'd2, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h0C, 4'hF, 32'h0, 8'h1C, 2'd2, 0, 32'h2);
        @(negedge clk);
        chk("irq_en_cleared", 64'(irq), 64'd0);
        @(posedge clk);
        #1;

        // Scratch byte strobes, sub-word address, unmapped offset.
        send(MEM_MSG_WRITE, BASE + 32'h14, 4'hF, 32'hAABBCCDD, 8'h21, 2'd0, 0, 32'd0);
        send(MEM_MSG_WRITE, BASE + 32'h14, 4'h5, 32'h11223344, 8'h22, 2'd0, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h14, 4'hF, 32'h0, 8'h23, 2'd3, 0, 32'hAA22CC44);
        send(MEM_MSG_READ, BASE + 32'h16, 4'h0, 32'h0, 8'h24, 2'd3, 0, 32'hAA22CC44);
        send(MEM_MSG_WRITE, BASE + 32'h40, 4'hF, 32'hDEADBEEF, 8'h25, 2'd0, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h40, 4'hF, 32'h0, 8'h26, 2'd0, 0, 32'd0);
        send(MEM_MSG_WRITE, BASE + 32'h1C, 4'h8, 32'h12345678, 8'h27, 2'd1, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h1C, 4'hF, 32'h0, 8'h28, 2'd1, 0, 32'h12000000);
        send(MEM_MSG_WRITE, BASE + 32'h0C, 4'h2, 32'h1, 8'h29, 2'd1, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h0C, 4'hF, 32'h0, 8'h2A, 2'd1, 0, 32'h2);
        drain();

        // Back-pressure: depth 2 fills, third request waits.
        resp_rdy = 1'b0;
        send(MEM_MSG_READ, BASE + 32'h14, 4'hF, 32'h0, 8'hA1, 2'd1, 0, 32'hAA22CC44);
        send(MEM_MSG_READ, BASE + 32'h1C, 4'hF, 32'h0, 8'hA2, 2'd2, 0, 32'h12000000);
        fork
            send(MEM_MSG_READ, BASE + 32'h40, 4'hF, 32'h0, 8'hA3, 2'd3, 0, 32'd0);
        join_none
        @(negedge clk);
        chk("bp_req_rdy_a", 64'(req_rdy), 64'd0);
        @(negedge clk);
        chk("bp_req_rdy_b", 64'(req_rdy), 64'd0);
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        wait fork;
        drain();

        // Counter wrap across 2^32 with the high-word snapshot.
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        bias = 64'h0000_0000_FFFF_FFFF - cyc;
        #2;
        release dut.cnt_q;
        send(MEM_MSG_READ, BASE + 32'h00, 4'hF, 32'h0, 8'hB1, 2'd0, 0, 32'hFFFFFFFF);
        send(MEM_MSG_READ, BASE + 32'h04, 4'hF, 32'h0, 8'hB2, 2'd0, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h00, 4'hF, 32'h0, 8'hB3, 2'd0, 0, 32'd1);
        send(MEM_MSG_READ, BASE + 32'h04, 4'hF, 32'h0, 8'hB4, 2'd0, 0, 32'd1);
        send(MEM_MSG_READ, BASE + 32'h00, 4'hF, 32'h0, 8'hB5, 2'd0, 1, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h04, 4'hF, 32'h0, 8'hB6, 2'd0, 2, 32'd0);
        drain();

        // Reset with two responses queued.
        resp_rdy = 1'b0;
        send(MEM_MSG_WRITE, BASE + 32'h10, 4'hF, 32'h5555, 8'hC1, 2'd0, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h10, 4'hF, 32'h0, 8'hC2, 2'd0, 0, 32'h5555);
        rst = 1'b1;
        sb.delete();
        bias = '0;
        snap_m = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_val", 64'(resp_val), 64'd0);
        chk("rst_req_rdy", 64'(req_rdy), 64'd1);
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        send(MEM_MSG_READ, BASE + 32'h10, 4'hF, 32'h0, 8'hD1, 2'd1, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h14, 4'hF, 32'h0, 8'hD2, 2'd1, 0, 32'd0);
        send(MEM_MSG_READ, BASE + 32'h08, 4'hF, 32'h0, 8'hD3, 2'd1, 0, 32'hFFFFFFFF);
        send(MEM_MSG_READ, BASE + 32'h00, 4'hF, 32'h0, 8'hD4, 2'd1, 0, 32'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
